score_scan_display: RTL

Reads the two 3-digit BCD player scores produced by the scoring counter and drives a 6-digit, time-multiplexed, active-low seven-segment display. A prescaler paces the digit scan. Both scores are snapshotted once per full scan frame, so a digit never tears mid-frame. Sits between the scoring logic and the board display pins, in the system clock domain.

---
 rtl/display_pkg.sv | 8 +
 rtl/bcd_to_seg7.sv | 29 ++
 rtl/score_scan_display.sv | 100 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the score scan display.
package display_pkg;
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK  = 7'h7F;
    localparam seg7_t SEG_DASH   = 7'h3F;
    localparam int    NUM_DIGITS = 6;
endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment glyph (bit 0 = a).
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output seg7_t      seg_n
);
    always_comb begin
        seg_n = SEG_DASH;
        if (blank) begin
            seg_n = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    seg_n = 7'b1000000;
                4'd1:    seg_n = 7'b1111001;
                4'd2:    seg_n = 7'b0100100;
                4'd3:    seg_n = 7'b0110000;
                4'd4:    seg_n = 7'b0011001;
                4'd5:    seg_n = 7'b0010010;
                4'd6:    seg_n = 7'b0000010;
                4'd7:    seg_n = 7'b1111000;
                4'd8:    seg_n = 7'b0000000;
                4'd9:    seg_n = 7'b0010000;
                default: seg_n = SEG_DASH;
            endcase
        end
    end
endmodule

// File: rtl/score_scan_display.sv
// Six-digit multiplexed score display with per-frame snapshot of both scores.
// Define SCORE_LZB_EN for per-player leading-zero blanking.
module score_scan_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [11:0] P1_points_hex,
    input  logic [11:0] P2_points_hex,
    output logic [6:0]  Seg_n,
    output logic [5:0]  An_n,
    output logic        Frame_done
);
    localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [11:0]   s1_q, s1_d, s2_q, s2_d;
    logic          load_pend_q, load_pend_d;
    seg7_t         seg_n_q, seg_n_d;
    logic [5:0]    an_n_q, an_n_d;
    logic          frame_done_q, frame_done_d;

    logic          tick, load;
    logic [11:0]   score;
    logic [1:0]    dsel;
    logic [3:0]    nibble;
    logic          blank;
    seg7_t         seg_dec;

    always_comb begin
        tick      = (div_cnt_q == DW'(REFRESH_DIV - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
        idx_d     = idx_q;
        if (tick) idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;

        load         = load_pend_q | (tick & (idx_q == 3'(NUM_DIGITS - 1)));
        load_pend_d  = 1'b0;
        s1_d         = load ? P1_points_hex : s1_q;
        s2_d         = load ? P2_points_hex : s2_q;
        frame_done_d = load;

        // Outputs are built from next-state values so the pins line up with
        // the new slot and new snapshot one cycle after they are decided.
        if (idx_d >= 3'd3) begin
            score = s2_d;
            dsel  = 2'(idx_d - 3'd3);
        end else begin
            score = s1_d;
            dsel  = idx_d[1:0];
        end
        case (dsel)
            2'd0:    nibble = score[3:0];
            2'd1:    nibble = score[7:4];
            default: nibble = score[11:8];
        endcase
`ifdef SCORE_LZB_EN
        blank = ((dsel == 2'd2) && (score[11:8] == 4'd0)) ||
                ((dsel == 2'd1) && (score[11:8] == 4'd0) && (score[7:4] == 4'd0));
`else
        blank = 1'b0;
`endif
        an_n_d  = ~(6'b000001 << idx_d);
        seg_n_d = seg_dec;
    end

    bcd_to_seg7 u_dec (
        .nibble (nibble),
        .blank  (blank),
        .seg_n  (seg_dec)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt_q    <= '0;
            idx_q        <= 3'd0;
            s1_q         <= 12'h000;
            s2_q         <= 12'h000;
            load_pend_q  <= 1'b1;
            seg_n_q      <= SEG_BLANK;
            an_n_q       <= 6'h3F;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            load_pend_q  <= load_pend_d;
            seg_n_q      <= seg_n_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign Seg_n      = seg_n_q;
    assign An_n       = an_n_q;
    assign Frame_done = frame_done_q;
endmodule
